// File: rtl/fifo_pop_stream_adapter_pkg.sv
// Shared defaults and sizing helpers for the FIFO pop-to-stream adapter.
package fifo_pop_stream_adapter_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_BUF_DEPTH  = 4;
    localparam int unsigned DEF_CNT_WIDTH  = 32;

    // Index width for a power-of-two ring of the given depth (never below 1 bit).
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_pop_stream_adapter_ring.sv
// Register-array circular buffer: push, pop, showahead head word and entry count.
module fifo_pop_stream_adapter_ring
    import fifo_pop_stream_adapter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEF_BUF_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   head_data_c,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    drop_c
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  full;
    logic                  do_pop;
    logic                  do_push;

    // A full ring still accepts a push when the head leaves in the same cycle.
    assign full        = (count == CNT_W'(DEPTH));
    assign do_pop      = pop & (count != '0);
    assign do_push     = push & (~full | do_pop);
    assign drop_c      = push & full & ~do_pop;
    assign head_data_c = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fifo_pop_stream_adapter.sv
// Pops a non-showahead FIFO on credit and re-presents the words as a valid/ready stream.
module fifo_pop_stream_adapter
    import fifo_pop_stream_adapter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned BUF_DEPTH  = DEF_BUF_DEPTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    output logic                        fifo_pop_enable,
    input  logic                        fifo_pop_valid,
    input  logic [DATA_WIDTH-1:0]       fifo_pop_data,
    input  logic                        fifo_pop_empty,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    input  logic                        out_ready,
    output logic [$clog2(BUF_DEPTH):0]  occupancy,
    output logic [CNT_WIDTH-1:0]        word_count,
    output logic                        protocol_error
);

    localparam int unsigned OCC_W = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned SUM_W = OCC_W + 1;

    logic armed;
    logic inflight;
    logic wr_valid;
    logic rd_fire;
    logic drop_c;

    // armed stays low for the first cycle after reset so a stale pop_valid is discarded.
    assign wr_valid  = fifo_pop_valid & armed;
    assign out_valid = (occupancy != '0);
    assign rd_fire   = out_valid & out_ready;

    // Only pop when the word, plus any already in flight, is guaranteed a buffer slot.
    assign fifo_pop_enable = armed & ~fifo_pop_empty &
                             ((SUM_W'(occupancy) + SUM_W'(inflight)) < SUM_W'(BUF_DEPTH));

    fifo_pop_stream_adapter_ring #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_ring (
        .clk         (clk),
        .reset_n     (reset_n),
        .push        (wr_valid),
        .push_data   (fifo_pop_data),
        .pop         (rd_fire),
        .head_data_c (out_data),
        .count       (occupancy),
        .drop_c      (drop_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed          <= 1'b0;
            inflight       <= 1'b0;
            word_count     <= '0;
            protocol_error <= 1'b0;
        end else begin
            armed    <= 1'b1;
            inflight <= fifo_pop_enable;
            if (rd_fire) begin
                word_count <= word_count + CNT_WIDTH'(1);
            end
            if ((wr_valid & ~inflight) | drop_c) begin
                protocol_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_pop_stream_adapter.sv
// Self-checking bench: behavioural FIFO source plus an in-order scoreboard of popped words.
module tb_fifo_pop_stream_adapter;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned OCC_W = 3;
    localparam int unsigned SRC_N = 2048;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             fifo_pop_enable;
    logic             fifo_pop_enable4;
    logic             fifo_pop_valid = 1'b0;
    logic [DW-1:0]    fifo_pop_data = '0;
    logic             fifo_pop_empty;
    logic             out_valid;
    logic             out_valid4;
    logic [DW-1:0]    out_data;
    logic [DW-1:0]    out_data4;
    logic             out_ready = 1'b0;
    logic [OCC_W-1:0] occupancy;
    logic [OCC_W-1:0] occupancy4;
    logic [31:0]      word_count;
    logic [3:0]       word_count4;
    logic             protocol_error;
    logic             protocol_error4;
    logic             inject_valid = 1'b0;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [DW-1:0] src_mem [SRC_N];
    int unsigned pushed_total = 0;
    int unsigned popped_total = 0;
    int unsigned sb_idx = 0;
    int unsigned delivered = 0;

    always #5 clk = ~clk;

    fifo_pop_stream_adapter #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .CNT_WIDTH(32)) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .fifo_pop_enable(fifo_pop_enable),
        .fifo_pop_valid (fifo_pop_valid),
        .fifo_pop_data  (fifo_pop_data),
        .fifo_pop_empty (fifo_pop_empty),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .occupancy      (occupancy),
        .word_count     (word_count),
        .protocol_error (protocol_error)
    );

    fifo_pop_stream_adapter #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .CNT_WIDTH(4)) u_dut_c4 (
        .clk            (clk),
        .reset_n        (reset_n),
        .fifo_pop_enable(fifo_pop_enable4),
        .fifo_pop_valid (fifo_pop_valid),
        .fifo_pop_data  (fifo_pop_data),
        .fifo_pop_empty (fifo_pop_empty),
        .out_valid      (out_valid4),
        .out_data       (out_data4),
        .out_ready      (out_ready),
        .occupancy      (occupancy4),
        .word_count     (word_count4),
        .protocol_error (protocol_error4)
    );

    // Behavioural non-showahead FIFO: data/valid appear one cycle after an accepted pop.
    assign fifo_pop_empty = (pushed_total == popped_total);

    always @(posedge clk) begin
        if (fifo_pop_enable && (popped_total < pushed_total)) begin
            fifo_pop_data <= src_mem[popped_total % SRC_N];
            popped_total  <= popped_total + 1;
        end
        fifo_pop_valid <= (fifo_pop_enable && (popped_total < pushed_total)) || inject_valid;
    end

    task automatic push_word(input logic [DW-1:0] w);
        src_mem[pushed_total % SRC_N] = w;
        pushed_total++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n      = 1'b0;
        out_ready    = 1'b0;
        inject_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        sb_idx    = popped_total;
        delivered = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", out_valid);
        else n_pass++;
        n_checks++;
        if (occupancy !== 3'd0) $display("FAIL reset_occupancy: got %0d expected 0", occupancy);
        else n_pass++;
        n_checks++;
        if (word_count !== 32'd0) $display("FAIL reset_word_count: got %0d expected 0", word_count);
        else n_pass++;
        n_checks++;
        if (protocol_error !== 1'b0) $display("FAIL reset_protocol_error: got %0b expected 0", protocol_error);
        else n_pass++;
        n_checks++;
        if (fifo_pop_enable !== 1'b0) $display("FAIL reset_pop_enable: got %0b expected 0", fifo_pop_enable);
        else n_pass++;
        apply_reset();
    endtask

    // Preloaded 0x1..0x8 with out_ready high: one word per cycle starting two cycles after the first pop.
    task automatic test_stream_in_order();
        logic exp_v;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        #1;
        n_checks++;
        if (fifo_pop_enable !== 1'b1) $display("FAIL first_pop_enable: got %0b expected 1", fifo_pop_enable);
        else n_pass++;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            exp_v = (k >= 2) && (k <= 9);
            n_checks++;
            if (out_valid !== exp_v) $display("FAIL stream_valid_c%0d: got %0b expected %0b", k, out_valid, exp_v);
            else n_pass++;
            if (exp_v && out_valid) begin
                n_checks++;
                if (out_data !== DW'(k - 1)) $display("FAIL stream_data_c%0d: got %0h expected %0h", k, out_data, k - 1);
                else n_pass++;
                sb_idx++;
                delivered++;
            end
        end
        n_checks++;
        if (word_count !== 32'd8) $display("FAIL stream_word_count: got %0d expected 8", word_count);
        else n_pass++;
        n_checks++;
        if (protocol_error !== 1'b0) $display("FAIL stream_protocol_error: got %0b expected 0", protocol_error);
        else n_pass++;
    endtask

    // Stalled sink: credit stops after DEPTH pops; releasing it drains 0x1..0x8 back to back.
    task automatic test_backpressure();
        int pops;
        pops = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (fifo_pop_enable) pops++;
            if (k >= 2) begin
                n_checks++;
                if (!(out_valid === 1'b1 && out_data === DW'(1)))
                    $display("FAIL stall_head_c%0d: got valid=%0b data=%0h expected valid=1 data=1", k, out_valid, out_data);
                else n_pass++;
            end
        end
        n_checks++;
        if (pops != DEPTH) $display("FAIL stall_pop_count: got %0d expected %0d", pops, DEPTH);
        else n_pass++;
        n_checks++;
        if (occupancy !== 3'(DEPTH)) $display("FAIL stall_occupancy: got %0d expected %0d", occupancy, DEPTH);
        else n_pass++;
        n_checks++;
        if (fifo_pop_enable !== 1'b0) $display("FAIL stall_pop_enable: got %0b expected 0", fifo_pop_enable);
        else n_pass++;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            n_checks++;
            if (!(out_valid === 1'b1 && out_data === DW'(k + 1)))
                $display("FAIL drain_word_%0d: got valid=%0b data=%0h expected valid=1 data=%0h", k, out_valid, out_data, k + 1);
            else n_pass++;
            sb_idx++;
            delivered++;
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL drain_empty: got %0b expected 0", out_valid);
        else n_pass++;
        n_checks++;
        if (word_count !== 32'(delivered)) $display("FAIL drain_word_count: got %0d expected %0d", word_count, delivered);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    // 1000 random words against a random sink: order, hold-under-stall and occupancy bound.
    task automatic test_random_backpressure();
        int          got;
        logic        prev_stall;
        logic [DW-1:0] prev_data;
        logic [DW-1:0] exp_d;
        got        = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        @(negedge clk);
        for (int i = 0; i < 1000; i++) push_word(DW'($urandom));
        for (int cyc = 0; cyc < 6000 && got < 1000; cyc++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                n_checks++;
                if (!(out_valid === 1'b1 && out_data === prev_data))
                    $display("FAIL rand_hold_c%0d: got valid=%0b data=%0h expected valid=1 data=%0h", cyc, out_valid, out_data, prev_data);
                else n_pass++;
            end
            n_checks++;
            if (occupancy > 3'(DEPTH)) $display("FAIL rand_occ_bound_c%0d: got %0d expected <= %0d", cyc, occupancy, DEPTH);
            else n_pass++;
            if (out_valid && out_ready) begin
                exp_d = src_mem[sb_idx % SRC_N];
                n_checks++;
                if (out_data !== exp_d) $display("FAIL rand_word_%0d: got %0h expected %0h", got, out_data, exp_d);
                else n_pass++;
                sb_idx++;
                delivered++;
                got++;
            end
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
        end
        n_checks++;
        if (got != 1000) $display("FAIL rand_timeout: got %0d words expected 1000", got);
        else n_pass++;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (word_count !== 32'(delivered)) $display("FAIL rand_word_count: got %0d expected %0d", word_count, delivered);
        else n_pass++;
        n_checks++;
        if (protocol_error !== 1'b0) $display("FAIL rand_protocol_error: got %0b expected 0", protocol_error);
        else n_pass++;
    endtask

    // Unsolicited pop_valid sets the sticky error one cycle after it is seen.
    task automatic test_protocol_error();
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        n_checks++;
        if (fifo_pop_enable !== 1'b0 || protocol_error !== 1'b0)
            $display("FAIL perr_idle: got enable=%0b perr=%0b expected 0/0", fifo_pop_enable, protocol_error);
        else n_pass++;
        inject_valid = 1'b1;
        @(negedge clk);
        inject_valid = 1'b0;
        #1;
        n_checks++;
        if (protocol_error !== 1'b0) $display("FAIL perr_early: got %0b expected 0", protocol_error);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (protocol_error !== 1'b1) $display("FAIL perr_set: got %0b expected 1", protocol_error);
        else n_pass++;
        n_checks++;
        if (occupancy !== 3'd1) $display("FAIL perr_written: got %0d expected 1", occupancy);
        else n_pass++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (protocol_error !== 1'b1) $display("FAIL perr_sticky_c%0d: got %0b expected 1", k, protocol_error);
            else n_pass++;
        end
    endtask

    // Reset with 3 words buffered and 1 in flight; stale pop_valid after release is ignored.
    task automatic test_reset_midstream();
        logic hit;
        apply_reset();
        @(negedge clk);
        #1;
        n_checks++;
        if (protocol_error !== 1'b0) $display("FAIL perr_cleared: got %0b expected 0", protocol_error);
        else n_pass++;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(DW'(32'hA0 + i));
        hit = 1'b0;
        for (int cyc = 0; cyc < 20 && !hit; cyc++) begin
            @(negedge clk);
            #1;
            if (occupancy == 3'd3) hit = 1'b1;
        end
        n_checks++;
        if (hit !== 1'b1) $display("FAIL mid_reach_three: got occupancy=%0d expected 3", occupancy);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || occupancy !== 3'd0)
            $display("FAIL mid_reset_flush: got valid=%0b occ=%0d expected 0/0", out_valid, occupancy);
        else n_pass++;
        n_checks++;
        if (word_count !== 32'd0 || word_count4 !== 4'd0)
            $display("FAIL mid_reset_count: got %0d/%0d expected 0/0", word_count, word_count4);
        else n_pass++;
        n_checks++;
        if (fifo_pop_enable !== 1'b0) $display("FAIL mid_reset_enable: got %0b expected 0", fifo_pop_enable);
        else n_pass++;
        @(negedge clk);
        inject_valid = 1'b1;
        @(negedge clk);
        inject_valid = 1'b0;
        reset_n      = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (protocol_error !== 1'b0 || occupancy !== 3'd0)
                $display("FAIL stale_valid_c%0d: got perr=%0b occ=%0d expected 0/0", k, protocol_error, occupancy);
            else n_pass++;
        end
        sb_idx    = popped_total;
        delivered = 0;
    endtask

    // 17 deliveries: the 4-bit counter wraps to 1 while the 32-bit one reads 17.
    task automatic test_count_wrap();
        int          got;
        logic [DW-1:0] exp_d;
        got = 0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) push_word(DW'(32'h100 + i));
        for (int cyc = 0; cyc < 200 && got < 17; cyc++) begin
            @(negedge clk);
            #1;
            exp_d = src_mem[sb_idx % SRC_N];
            if (out_valid4 && out_ready) begin
                n_checks++;
                if (out_data4 !== exp_d) $display("FAIL wrap_c4_word_%0d: got %0h expected %0h", got, out_data4, exp_d);
                else n_pass++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_data !== exp_d) $display("FAIL wrap_word_%0d: got %0h expected %0h", got, out_data, exp_d);
                else n_pass++;
                sb_idx++;
                delivered++;
                got++;
            end
        end
        n_checks++;
        if (got != 17) $display("FAIL wrap_timeout: got %0d words expected 17", got);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (word_count4 !== 4'(delivered % 16)) $display("FAIL wrap_count4: got %0d expected %0d", word_count4, delivered % 16);
        else n_pass++;
        n_checks++;
        if (word_count !== 32'(delivered)) $display("FAIL wrap_count32: got %0d expected %0d", word_count, delivered);
        else n_pass++;
        n_checks++;
        if (occupancy4 !== 3'd0 || fifo_pop_enable4 !== 1'b0 || protocol_error4 !== 1'b0)
            $display("FAIL wrap_c4_idle: got occ=%0d en=%0b perr=%0b expected 0/0/0", occupancy4, fifo_pop_enable4, protocol_error4);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream_in_order();
        test_backpressure();
        test_random_backpressure();
        test_protocol_error();
        test_reset_midstream();
        test_count_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
